// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    // Fetches are always full-word reads.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data has priority unless fetch has lost STARVE_LIMIT times in a row.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_if,
    output logic                grant_d
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    always_comb begin
        grant_if = if_req & (~d_req | (starve_cnt == LIMIT));
        grant_d  = d_req & ~grant_if;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one ready/valid memory port between instruction fetch and data access,
// one outstanding transaction at a time, with per-requester completion pulses and stalls.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ifReq,
    input  logic [ADDR_W-1:0] i_ifAddr,
    output logic              o_ifValid,
    output logic [DATA_W-1:0] o_ifData,
    output logic              o_ifStall,
    input  logic              i_dReq,
    input  logic              i_dWe,
    input  logic [ADDR_W-1:0] i_dAddr,
    input  logic [DATA_W-1:0] i_dWdata,
    input  logic [2:0]        i_dFunct3,
    output logic              o_dValid,
    output logic [DATA_W-1:0] o_dRdata,
    output logic              o_dStall,
    output logic              o_memReq,
    output logic              o_memWe,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memWdata,
    output logic [2:0]        o_memFunct3,
    input  logic              i_memReady,
    input  logic              i_memRvalid,
    input  logic [DATA_W-1:0] i_memRdata,
    output logic              o_err
);

    arb_state_e          state_q, state_d;
    logic                winner_if_q, winner_if_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q, err_d;
    logic                grant_if, grant_d;

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .if_req    (i_ifReq),
        .d_req     (i_dReq),
        .starve_cnt(starve_q),
        .grant_if  (grant_if),
        .grant_d   (grant_d)
    );

    always_comb begin
        // NOTE: every next-state value gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        winner_if_d = winner_if_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        starve_d    = starve_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_data_d   = '0;
        d_rdata_d   = '0;
        err_d       = err_q;

        unique case (state_q)
            ARB_IDLE: begin
                err_d = err_q | i_memRvalid;
                if (grant_if) begin
                    state_d     = ARB_REQ;
                    winner_if_d = 1'b1;
                    addr_d      = i_ifAddr;
                    we_d        = 1'b0;
                    wdata_d     = '0;
                    funct3_d    = FUNCT3_WORD;
                    starve_d    = '0;
                end else if (grant_d) begin
                    state_d     = ARB_REQ;
                    winner_if_d = 1'b0;
                    addr_d      = i_dAddr;
                    we_d        = i_dWe;
                    wdata_d     = i_dWdata;
                    funct3_d    = i_dFunct3;
                    if (i_ifReq) starve_d = starve_q + 4'd1;
                end
            end
            ARB_REQ: begin
                err_d = err_q | i_memRvalid;
                if (i_memReady) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // A response coinciding with a ready is treated as spurious and not consumed.
                if (i_memRvalid && i_memReady) begin
                    err_d = 1'b1;
                end else if (i_memRvalid) begin
                    state_d = ARB_RESP;
                    if (winner_if_q) begin
                        if_valid_d = 1'b1;
                        if_data_d  = i_memRdata;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = i_memRdata;
                    end
                end
            end
            ARB_RESP: begin
                err_d   = err_q | i_memRvalid;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all decisions are made in the always_comb above.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the latched request fields drive memory pins directly, so they are reset along with the FSM.
            state_q     <= ARB_IDLE;
            winner_if_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            starve_q    <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_if_q <= winner_if_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            starve_q    <= starve_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        o_ifValid   = if_valid_q;
        o_ifData    = if_data_q;
        o_ifStall   = i_ifReq & ~if_valid_q;
        o_dValid    = d_valid_q;
        o_dRdata    = d_rdata_q;
        o_dStall    = i_dReq & ~d_valid_q;
        o_memReq    = (state_q == ARB_REQ);
        o_memWe     = we_q;
        o_memAddr   = addr_q;
        o_memWdata  = wdata_q;
        o_memFunct3 = funct3_q;
        o_err       = err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grants,
// memory fields and completion cycles; a monitor compares every cycle.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    typedef struct packed {
        logic          is_if;
        logic [DW-1:0] data;
        int            cyc;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [2:0]    d_f3 = '0;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          if_valid, if_stall, d_valid, d_stall;
    logic [DW-1:0] if_data, d_rdata, mem_wdata;
    logic          mem_req, mem_we, err;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_f3;

    mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_ifReq    (if_req),
        .i_ifAddr   (if_addr),
        .o_ifValid  (if_valid),
        .o_ifData   (if_data),
        .o_ifStall  (if_stall),
        .i_dReq     (d_req),
        .i_dWe      (d_we),
        .i_dAddr    (d_addr),
        .i_dWdata   (d_wdata),
        .i_dFunct3  (d_f3),
        .o_dValid   (d_valid),
        .o_dRdata   (d_rdata),
        .o_dStall   (d_stall),
        .o_memReq   (mem_req),
        .o_memWe    (mem_we),
        .o_memAddr  (mem_addr),
        .o_memWdata (mem_wdata),
        .o_memFunct3(mem_f3),
        .i_memReady (mem_ready),
        .i_memRvalid(mem_rvalid),
        .i_memRdata (mem_rdata),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // Reference model state
    resp_t         resp_q[$];
    bit            seen_log[$];
    bit            m_free = 1'b1;
    bit            m_req_active = 1'b0;
    bit            m_in_wait = 1'b0;
    bit            m_is_if = 1'b0;
    bit            m_err = 1'b0;
    int            m_starve = 0;
    int            busy_cnt = 0;
    int            wait_left = 0;
    logic [AW-1:0] exp_addr = '0;
    logic          exp_we = 1'b0;
    logic [DW-1:0] exp_wdata = '0;
    logic [2:0]    exp_f3 = '0;

    // Stimulus knobs
    bit            mon_en = 1'b0;
    int            req_pct = 0;
    int            ready_pct = 100;
    int            max_wait = 0;
    bit            drop_en = 1'b0;
    bit            spur_en = 1'b0;
    bit            force_spur = 1'b0;
    bit            rdata_fixed_en = 1'b0;
    logic [DW-1:0] rdata_fixed = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // One cycle of requesters, memory and model, driven just after a falling edge.
    task automatic step_body();
        logic  win_if;
        resp_t r;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 1) begin
                if (m_is_if) if_req = 1'b0;
                else d_req = 1'b0;
            end
            if (busy_cnt == 0) m_free = 1'b1;
        end

        if (drop_en && m_in_wait && m_is_if && if_req && $urandom_range(99) < 20) if_req = 1'b0;

        if (!if_req && !(!m_free && m_is_if) && $urandom_range(99) < req_pct) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req && !(!m_free && !m_is_if) && $urandom_range(99) < req_pct) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_f3    = 3'($urandom_range(7));
        end

        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (m_req_active) begin
            if ($urandom_range(99) < ready_pct) begin
                mem_ready    = 1'b1;
                m_req_active = 1'b0;
                m_in_wait    = 1'b1;
                wait_left    = $urandom_range(max_wait);
            end
        end else if (m_in_wait) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                mem_rvalid = 1'b1;
                if (rdata_fixed_en) mem_rdata = rdata_fixed;
                m_in_wait = 1'b0;
                busy_cnt  = 2;
                r.is_if   = m_is_if;
                r.data    = mem_rdata;
                r.cyc     = cyc + 1;
                resp_q.push_back(r);
            end
        end

        if (m_free && (if_req || d_req)) begin
            if (if_req && d_req) begin
                win_if   = (m_starve == LIM);
                m_starve = win_if ? 0 : m_starve + 1;
            end else begin
                win_if = if_req;
                if (if_req) m_starve = 0;
            end
            m_is_if      = win_if;
            m_free       = 1'b0;
            m_req_active = 1'b1;
            exp_addr     = win_if ? if_addr : d_addr;
            exp_we       = win_if ? 1'b0 : d_we;
            exp_wdata    = d_wdata;
            exp_f3       = win_if ? 3'b010 : d_f3;
        end else if (m_free && (force_spur || (spur_en && $urandom_range(99) < 5))) begin
            mem_rvalid = 1'b1;
            m_err      = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        step_body();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_if_valid"}, if_valid, 0);
        check({tag, "_d_valid"}, d_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_f3"}, mem_f3, 0);
        check({tag, "_if_data"}, if_data, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_if_stall"}, if_stall, 0);
        check({tag, "_d_stall"}, d_stall, 0);
    endtask

    always @(negedge clk) begin
        logic          ei;
        logic          ed;
        logic [DW-1:0] hd;
        if (mon_en) begin
            ei = 1'b0;
            ed = 1'b0;
            hd = '0;
            if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
                ei = resp_q[0].is_if;
                ed = !resp_q[0].is_if;
                hd = resp_q[0].data;
                void'(resp_q.pop_front());
            end
            check("if_valid", if_valid, ei);
            check("d_valid", d_valid, ed);
            check("if_data", if_data, ei ? hd : '0);
            check("d_rdata", d_rdata, ed ? hd : '0);
            check("if_stall", if_stall, if_req & ~ei);
            check("d_stall", d_stall, d_req & ~ed);
            check("err", err, m_err);
            check("mem_req", mem_req, m_req_active);
            if (m_req_active) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                check("mem_f3", mem_f3, exp_f3);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (if_valid === 1'b1) seen_log.push_back(1'b1);
            else if (d_valid === 1'b1) seen_log.push_back(1'b0);
        end
    end

    initial begin
        bit pat [10];
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset values
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        mon_en = 1'b1;

        // Directed fetch of 0x40 with a zero-wait memory
        rdata_fixed_en = 1'b1;
        rdata_fixed    = 32'h0050_0093;
        if_req         = 1'b1;
        if_addr        = 32'h40;
        step_body();
        repeat (5) step();
        rdata_fixed_en = 1'b0;
        check("fetch_only_done", (seen_log.size() == 1 && seen_log[0]) ? 1'b1 : 1'b0, 1);

        // Both requesters always pending: starvation guard order
        seen_log.delete();
        req_pct = 100;
        repeat (44) step();
        check("starve_grants", (seen_log.size() >= 10) ? 1'b1 : 1'b0, 1);
        if (seen_log.size() >= 10)
            for (int i = 0; i < 10; i++) check($sformatf("starve_order_%0d", i), seen_log[i], pat[i]);

        // Random traffic with memory wait states and fetch drops in WAIT
        req_pct   = 30;
        ready_pct = 60;
        max_wait  = 3;
        drop_en   = 1'b1;
        repeat (600) step();

        // Spurious response in IDLE, then a normal fetch
        drop_en   = 1'b0;
        req_pct   = 0;
        ready_pct = 100;
        max_wait  = 0;
        repeat (20) step();
        check("err_before_spur", err, 0);
        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        repeat (2) step();
        check("err_after_spur", err, 1);
        @(negedge clk);
        #1;
        seen_log.delete();
        if_req  = 1'b1;
        if_addr = 32'h80;
        step_body();
        repeat (5) step();
        check("fetch_after_err", (seen_log.size() == 1 && seen_log[0]) ? 1'b1 : 1'b0, 1);

        spur_en   = 1'b1;
        req_pct   = 30;
        ready_pct = 60;
        max_wait  = 3;
        repeat (300) step();
        check("err_sticky", err, 1);

        // Reset while waiting on memory, then a fresh load
        spur_en   = 1'b0;
        req_pct   = 50;
        ready_pct = 100;
        max_wait  = 5;
        for (int i = 0; i < 60 && !m_in_wait; i++) step();
        @(posedge clk);
        #2;
        mon_en     = 1'b0;
        rst        = 1'b1;
        if_req     = 1'b0;
        d_req      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check_all_zero("midreset");
        resp_q.delete();
        m_free       = 1'b1;
        m_req_active = 1'b0;
        m_in_wait    = 1'b0;
        m_is_if      = 1'b0;
        m_err        = 1'b0;
        m_starve     = 0;
        busy_cnt     = 0;
        wait_left    = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        mon_en    = 1'b1;
        req_pct   = 0;
        max_wait  = 0;
        seen_log.delete();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h200;
        d_f3      = 3'b010;
        step_body();
        repeat (5) step();
        check("load_after_reset", (seen_log.size() == 1 && !seen_log[0]) ? 1'b1 : 1'b0, 1);

        repeat (4) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
